// File: rtl/crossbar_nxn_arb.sv
// Registered N x N crossbar with a valid/ready handshake on every lane.
// Each output has its own arbiter and a one-entry output register. An output
// slot can drain and refill on the same edge, so every output can move one
// word per cycle.
// ARB_MODE 0 is round-robin: the search starts at ptr, and ptr moves to one
// past the winner after every grant. ARB_MODE 1 is fixed priority: the lowest
// input index wins.
module crossbar_nxn_arb #(
  parameter int N        = 4,
  parameter int W        = 4,
  parameter int ARB_MODE = 0,
  localparam int SW      = (N > 1) ? $clog2(N) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    in_valid,
  output logic [N-1:0]    in_ready,
  input  logic [N*W-1:0]  in_data,
  input  logic [N*SW-1:0] in_dest,
  output logic [N-1:0]    out_valid,
  input  logic [N-1:0]    out_ready,
  output logic [N*W-1:0]  out_data,
  output logic [N*SW-1:0] out_src
);

  logic [N-1:0]  req [N];      // req[j][i]: input i targets output j
  logic [N-1:0]  slot_free;
  logic [N-1:0]  gnt_vld;
  logic [SW-1:0] gnt_src [N];
  logic [SW-1:0] ptr [N];
  logic [SW-1:0] idx;

  // Decode each input's destination into a per-output request vector.
  always_comb begin
    for (int j = 0; j < N; j++) begin
      req[j] = '0;
      for (int i = 0; i < N; i++) begin
        req[j][i] = in_valid[i] && (in_dest[i*SW +: SW] == SW'(j));
      end
    end
  end

  // An output slot can take a new word when it is empty or is being drained now.
  always_comb begin
    for (int j = 0; j < N; j++) begin
      slot_free[j] = !out_valid[j] || out_ready[j];
    end
  end

  // Per-output arbitration. N is a power of two, so the SW-bit index wraps naturally.
  always_comb begin
    gnt_vld  = '0;
    in_ready = '0;
    idx      = '0;
    for (int j = 0; j < N; j++) begin
      gnt_src[j] = '0;
      if (slot_free[j]) begin
        for (int k = 0; k < N; k++) begin
          idx = ((ARB_MODE == 1) ? '0 : ptr[j]) + SW'(k);
          if (!gnt_vld[j] && req[j][idx]) begin
            gnt_vld[j] = 1'b1;
            gnt_src[j] = idx;
          end
        end
      end
      // Each input targets one output, so at most one grant per input sets its bit.
      if (gnt_vld[j] && rst_n) begin
        in_ready[gnt_src[j]] = 1'b1;
      end
    end
  end

  // Output registers and round-robin pointers: load on grant, clear on drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= '0;
      out_data  <= '0;
      out_src   <= '0;
      for (int j = 0; j < N; j++) begin
        ptr[j] <= '0;
      end
    end else begin
      for (int j = 0; j < N; j++) begin
        if (gnt_vld[j]) begin
          out_data[j*W +: W]   <= in_data[int'(gnt_src[j])*W +: W];
          out_src[j*SW +: SW]  <= gnt_src[j];
          out_valid[j]         <= 1'b1;
          if (ARB_MODE == 0) begin
            ptr[j] <= gnt_src[j] + SW'(1);
          end
        end else if (out_ready[j]) begin
          out_valid[j] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_crossbar_nxn_arb.sv
// Bench for crossbar_nxn_arb. A round-robin instance and a fixed-priority
// instance share the same stimulus. A cycle-level reference model predicts
// in_ready and pushes each granted word into a per-output scoreboard queue.
// A separate monitor pops those queues as the outputs are drained.
module tb_crossbar_nxn_arb;
  localparam int N  = 4;
  localparam int W  = 4;
  localparam int SW = 2;

  typedef struct {
    int data;
    int src;
  } item_t;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic [N-1:0]    in_valid;
  logic [N*W-1:0]  in_data;
  logic [N*SW-1:0] in_dest;
  logic [N-1:0]    out_ready;

  logic [N-1:0]    rdy [2];
  logic [N-1:0]    ov  [2];
  logic [N*W-1:0]  od  [2];
  logic [N*SW-1:0] os  [2];

  int total = 0;
  int bad   = 0;
  int pushed = 0;

  // Reference model state, indexed [instance][output]. Instance 0 is round-robin.
  bit    m_full [2][N];
  int    m_ptr  [2][N];
  int    m_gnt  [2][N];
  item_t sb [2*N][$];
  logic [N-1:0] exp_rdy;
  int    mi;
  logic [N-1:0] acc;

  crossbar_nxn_arb #(.N(N), .W(W), .ARB_MODE(0)) u_rr (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[0]),
    .in_data(in_data), .in_dest(in_dest), .out_valid(ov[0]),
    .out_ready(out_ready), .out_data(od[0]), .out_src(os[0])
  );

  crossbar_nxn_arb #(.N(N), .W(W), .ARB_MODE(1)) u_fp (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[1]),
    .in_data(in_data), .in_dest(in_dest), .out_valid(ov[1]),
    .out_ready(out_ready), .out_data(od[1]), .out_src(os[1])
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: choose each output's winner from the rules, then check in_ready.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      exp_rdy = '0;
      for (int j = 0; j < N; j++) begin
        m_gnt[d][j] = -1;
        if (rst_n && (!m_full[d][j] || out_ready[j])) begin
          for (int k = 0; k < N; k++) begin
            mi = (d == 1) ? k : (m_ptr[d][j] + k) % N;
            if (m_gnt[d][j] < 0 && in_valid[mi] && int'(in_dest[mi*SW +: SW]) == j) begin
              m_gnt[d][j] = mi;
              exp_rdy[mi] = 1'b1;
            end
          end
        end
      end
      check($sformatf("in_ready_dut%0d", d), int'(rdy[d]), int'(exp_rdy));
    end
  end

  // Model: at each edge, commit the chosen winners and queue the words they deliver.
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      for (int j = 0; j < N; j++) begin
        if (!rst_n) begin
          m_full[d][j] = 1'b0;
          m_ptr[d][j]  = 0;
          sb[d*N+j].delete();
        end else if (m_gnt[d][j] >= 0) begin
          item_t it;
          it.src  = m_gnt[d][j];
          it.data = int'(in_data[m_gnt[d][j]*W +: W]);
          sb[d*N+j].push_back(it);
          pushed++;
          m_full[d][j] = 1'b1;
          if (d == 0) m_ptr[d][j] = (m_gnt[d][j] + 1) % N;
        end else if (out_ready[j]) begin
          m_full[d][j] = 1'b0;
        end
      end
    end
  end

  // Monitor: compare the output registers against the scoreboard and pop on drain.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      for (int j = 0; j < N; j++) begin
        if (!rst_n) begin
          check($sformatf("out_valid_in_reset_dut%0d_o%0d", d, j), int'(ov[d][j]), 0);
        end else begin
          check($sformatf("out_valid_dut%0d_o%0d", d, j), int'(ov[d][j]),
                (sb[d*N+j].size() > 0) ? 1 : 0);
          if (ov[d][j] && sb[d*N+j].size() > 0) begin
            check($sformatf("out_data_dut%0d_o%0d", d, j), int'(od[d][j*W +: W]),
                  sb[d*N+j][0].data);
            check($sformatf("out_src_dut%0d_o%0d", d, j), int'(os[d][j*SW +: SW]),
                  sb[d*N+j][0].src);
            if (out_ready[j]) void'(sb[d*N+j].pop_front());
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    in_valid  = '1;
    in_data   = '0;
    in_dest   = '0;
    out_ready = '1;

    // Reset with every input requesting.
    #1 rst_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      check("reset_in_ready", int'(rdy[d]), 0);
      check("reset_out_valid", int'(ov[d]), 0);
      check("reset_out_data", int'(od[d]), 0);
      check("reset_out_src", int'(os[d]), 0);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    in_valid = '0;

    // Permutation: input i goes to output 3-i.
    @(posedge clk); #1;
    in_valid = 4'hF;
    in_data  = 16'hDCBA;
    in_dest  = 8'h1B;
    #1;
    check("perm_in_ready_rr", int'(rdy[0]), 4'hF);
    check("perm_in_ready_fp", int'(rdy[1]), 4'hF);
    @(posedge clk); #1;
    check("perm_out_valid", int'(ov[0]), 4'hF);
    check("perm_out_data", int'(od[0]), 16'hABCD);
    check("perm_out_src", int'(os[0]), 8'h1B);
    in_valid = '0;
    @(posedge clk); #1;

    // Round-robin contention on output 0, then an asynchronous reset mid-stream.
    in_valid = 4'hF;
    in_dest  = '0;
    in_data  = 16'h4321;
    for (int e = 0; e < 7; e++) begin
      #1;
      check($sformatf("rr_in_ready_%0d", e), int'(rdy[0]), 1 << (e % 4));
      @(posedge clk); #1;
      check($sformatf("rr_out_src_%0d", e), int'(os[0][1:0]), e % 4);
      check($sformatf("rr_out_data_%0d", e), int'(od[0][3:0]), (e % 4) + 1);
    end
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_out_valid_rr", int'(ov[0]), 0);
    check("async_rst_out_valid_fp", int'(ov[1]), 0);
    check("async_rst_in_ready", int'(rdy[0]), 0);
    @(posedge clk); #1 rst_n = 1'b1;
    #1;
    check("post_rst_first_grant", int'(rdy[0]), 4'b0001);
    @(posedge clk); #1;
    check("post_rst_out_src", int'(os[0][1:0]), 0);
    in_valid = '0;
    @(posedge clk); #1;

    // Backpressure: output 0 holds 5 while its sink stalls, then refills with no bubble.
    in_valid  = 4'b0100;
    in_data   = 16'h0500;
    in_dest   = '0;
    out_ready = 4'hF;
    @(posedge clk); #1;
    out_ready = 4'b1110;
    in_valid  = 4'b0010;
    in_data   = 16'h0090;
    for (int c = 0; c < 3; c++) begin
      #1;
      check($sformatf("stall_in_ready_%0d", c), int'(rdy[0][1]), 0);
      check($sformatf("stall_out_data_%0d", c), int'(od[0][3:0]), 5);
      @(posedge clk); #1;
    end
    out_ready = 4'hF;
    #1;
    check("unstall_in_ready", int'(rdy[0][1]), 1);
    @(posedge clk); #1;
    check("unstall_out_data", int'(od[0][3:0]), 9);
    check("unstall_out_src", int'(os[0][1:0]), 1);
    check("unstall_out_valid", int'(ov[0][0]), 1);
    in_valid = '0;
    @(posedge clk); #1;

    // Fixed priority: inputs 1 and 2 both target output 1.
    in_valid = 4'b0110;
    in_dest  = 8'h14;
    in_data  = 16'h0760;
    for (int c = 0; c < 4; c++) begin
      #1;
      check($sformatf("fp_in_ready_%0d", c), int'(rdy[1]), 4'b0010);
      @(posedge clk); #1;
      check($sformatf("fp_out_src_%0d", c), int'(os[1][3:2]), 1);
    end
    in_valid = 4'b0100;
    #1;
    check("fp_in_ready_after_drop", int'(rdy[1]), 4'b0100);
    @(posedge clk); #1;
    check("fp_out_src_after_drop", int'(os[1][3:2]), 2);
    check("fp_out_data_after_drop", int'(od[1][7:4]), 7);
    in_valid = '0;
    @(posedge clk); #1;

    // Random traffic. Inputs hold their request until the round-robin instance accepts it.
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      acc = rdy[0];
      @(posedge clk); #1;
      for (int i = 0; i < N; i++) begin
        if (!in_valid[i] || acc[i]) begin
          in_valid[i]           = ($urandom_range(0, 3) != 0);
          in_data[i*W +: W]     = W'($urandom);
          in_dest[i*SW +: SW]   = SW'($urandom);
        end
        out_ready[i] = ($urandom_range(0, 3) != 0);
      end
    end

    in_valid  = '0;
    out_ready = '1;
    repeat (4) @(posedge clk);
    @(negedge clk); #1;
    check("scoreboard_traffic_seen", (pushed > 500) ? 1 : 0, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
